nova_alu: RTL and testbench

- Arithmetic/logic unit for Nova "compute" instructions (inst bit 0 = 1), instantiated by the CPU core.
- Combinationally produces the 16-bit result and the skip decision.
- Owns the architectural Carry flag and commits it once per executed compute instruction.
- The CPU writes the result to the destination accumulator unless no-load is set, and adds 2 to PC when skip is asserted.

---
 rtl/nova_defs.sv | 62 ++++++
 rtl/nova_alu.sv | 158 +++++++++++++++
 tb/tb_nova_alu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/nova_defs.sv
// Shared field positions and code points for Nova compute instructions.
// Bit 0 of an instruction word is the MSB, so every field is given as [msb_idx:lsb_idx].
package nova_defs;

  localparam int CM_COMPUTE       = 0;
  localparam int CM_SRCACC_MSB    = 1;
  localparam int CM_SRCACC_LSB    = 2;
  localparam int CM_DSTACC_MSB    = 3;
  localparam int CM_DSTACC_LSB    = 4;
  localparam int CM_FUNC_MSB      = 5;
  localparam int CM_FUNC_LSB      = 7;
  localparam int CM_SHIFT_MSB     = 8;
  localparam int CM_SHIFT_LSB     = 9;
  localparam int CM_CARRY_MSB     = 10;
  localparam int CM_CARRY_LSB     = 11;
  localparam int CM_LOAD          = 12;
  localparam int CM_SKIP_MSB      = 13;
  localparam int CM_SKIP_LSB      = 15;

  typedef enum logic [2:0] {
    FN_COM = 3'd0,
    FN_NEG = 3'd1,
    FN_MOV = 3'd2,
    FN_INC = 3'd3,
    FN_ADC = 3'd4,
    FN_SUB = 3'd5,
    FN_ADD = 3'd6,
    FN_AND = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_L    = 2'd1,
    SH_R    = 2'd2,
    SH_S    = 2'd3
  } shift_e;

  typedef enum logic [1:0] {
    CB_CUR  = 2'd0,
    CB_ZERO = 2'd1,
    CB_ONE  = 2'd2,
    CB_COMP = 2'd3
  } cbase_e;

  typedef enum logic [2:0] {
    SK_NEVER = 3'd0,
    SK_SKP   = 3'd1,
    SK_SZC   = 3'd2,
    SK_SNC   = 3'd3,
    SK_SZR   = 3'd4,
    SK_SNR   = 3'd5,
    SK_SEZ   = 3'd6,
    SK_SBN   = 3'd7
  } skip_e;

  // 17-bit sum whose MSB is the carry out of the 16-bit add.
  function automatic logic [16:0] add17(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

endpackage

// File: rtl/nova_alu.sv
// Nova compute-instruction ALU: combinational result/skip, registered Carry flag.
// Result and skip are zero-latency; Carry commits on the exec edge, no backpressure.
module nova_alu
  import nova_defs::*;
(
  input  logic        pclk,
  input  logic        prst,
  input  logic [0:15] inst,
  input  logic [0:15] op1,
  input  logic [0:15] op2,
  input  logic        exec,
  output logic [0:15] result,
  output logic        skip,
  output logic        carry
);

  func_e       func;
  shift_e      shift;
  cbase_e      cbase;
  skip_e       skcond;
  logic        cb;
  logic [16:0] sum;
  logic [0:15] v;
  logic        c;
  logic [0:15] r;
  logic        c_sh;
  logic        r_zero;
  logic        commit;
  logic        carry_d;
  logic        carry_q;

  // Accumulator selects are decoded by the CPU; the ALU only sees their values.
  logic        unused_acc_fields;
  assign unused_acc_fields = ^{inst[CM_SRCACC_MSB:CM_SRCACC_LSB],
                               inst[CM_DSTACC_MSB:CM_DSTACC_LSB]};

  assign func   = func_e'(inst[CM_FUNC_MSB:CM_FUNC_LSB]);
  assign shift  = shift_e'(inst[CM_SHIFT_MSB:CM_SHIFT_LSB]);
  assign cbase  = cbase_e'(inst[CM_CARRY_MSB:CM_CARRY_LSB]);
  assign skcond = skip_e'(inst[CM_SKIP_MSB:CM_SKIP_LSB]);

  always_comb begin
    cb = carry_q;
    case (cbase)
      CB_CUR:  cb = carry_q;
      CB_ZERO: cb = 1'b0;
      CB_ONE:  cb = 1'b1;
      CB_COMP: cb = ~carry_q;
      default: cb = carry_q;
    endcase
  end

  // Arithmetic functions toggle the base carry on a 16-bit carry out.
  always_comb begin
    sum = 17'd0;
    v   = op1;
    c   = cb;
    case (func)
      FN_COM: begin
        v = ~op1;
      end
      FN_NEG: begin
        sum = add17(~op1, 16'd0, 1'b1);
        v   = sum[15:0];
        c   = cb ^ sum[16];
      end
      FN_MOV: begin
        v = op1;
      end
      FN_INC: begin
        sum = add17(op1, 16'd0, 1'b1);
        v   = sum[15:0];
        c   = cb ^ sum[16];
      end
      FN_ADC: begin
        sum = add17(~op1, op2, 1'b0);
        v   = sum[15:0];
        c   = cb ^ sum[16];
      end
      FN_SUB: begin
        sum = add17(op2, ~op1, 1'b1);
        v   = sum[15:0];
        c   = cb ^ sum[16];
      end
      FN_ADD: begin
        sum = add17(op1, op2, 1'b0);
        v   = sum[15:0];
        c   = cb ^ sum[16];
      end
      FN_AND: begin
        v = op1 & op2;
      end
      default: begin
        v = op1;
      end
    endcase
  end

  always_comb begin
    r    = v;
    c_sh = c;
    case (shift)
      SH_NONE: begin
        r    = v;
        c_sh = c;
      end
      SH_L: begin
        r    = {v[1:15], c};
        c_sh = v[0];
      end
      SH_R: begin
        r    = {c, v[0:14]};
        c_sh = v[15];
      end
      SH_S: begin
        r    = {v[8:15], v[0:7]};
        c_sh = c;
      end
      default: begin
        r    = v;
        c_sh = c;
      end
    endcase
  end

  assign r_zero = (r == 16'd0);

  // Skip is decided on the post-shift pair even when no-load suppresses the store.
  always_comb begin
    skip = 1'b0;
    case (skcond)
      SK_NEVER: skip = 1'b0;
      SK_SKP:   skip = 1'b1;
      SK_SZC:   skip = ~c_sh;
      SK_SNC:   skip = c_sh;
      SK_SZR:   skip = r_zero;
      SK_SNR:   skip = ~r_zero;
      SK_SEZ:   skip = ~c_sh | r_zero;
      SK_SBN:   skip = c_sh & ~r_zero;
      default:  skip = 1'b0;
    endcase
  end

  assign result  = r;
  assign commit  = exec & inst[CM_COMPUTE] & ~inst[CM_LOAD];
  assign carry_d = commit ? c_sh : carry_q;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;

endmodule

// File: tb/tb_nova_alu.sv
// Directed-vector bench for nova_alu; stimulus queues expectations, a negedge monitor checks them.
module tb_nova_alu;

  logic        pclk;
  logic        prst;
  logic [15:0] inst;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        exec;
  logic [15:0] result;
  logic        skip;
  logic        carry;

  typedef struct packed {
    logic        is_carry;
    logic [15:0] r;
    logic        s;
    logic        c;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld;
  int   n_cmp;
  int   n_bad;

  nova_alu dut (
    .pclk   (pclk),
    .prst   (prst),
    .inst   (inst),
    .op1    (op1),
    .op2    (op2),
    .result (result),
    .skip   (skip),
    .exec   (exec),
    .carry  (carry)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Fields in order: func, shift, carry base, no-load, skip.
  function automatic logic [15:0] mk(input logic [2:0] f, input logic [1:0] sh,
                                     input logic [1:0] cbs, input logic nl,
                                     input logic [2:0] sk);
    return {1'b1, 2'b00, 2'b00, f, sh, cbs, nl, sk};
  endfunction

  always @(negedge pclk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got a check strobe, required a queued expectation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_carry) begin
          n_cmp++;
          if (carry !== e.c) begin
            n_bad++;
            $display("FAIL carry @%0t: got %b required %b", $time, carry, e.c);
          end
        end else begin
          n_cmp++;
          if (result !== e.r) begin
            n_bad++;
            $display("FAIL result @%0t: inst=%h got %h required %h", $time, inst, result, e.r);
          end
          n_cmp++;
          if (skip !== e.s) begin
            n_bad++;
            $display("FAIL skip @%0t: inst=%h got %b required %b", $time, inst, skip, e.s);
          end
        end
      end
    end
  end

  task automatic chk_carry(input logic c);
    @(posedge pclk);
    #1;
    exp_q.push_back('{is_carry: 1'b1, r: 16'h0, s: 1'b0, c: c});
    chk_vld = 1'b1;
    @(posedge pclk);
    #1;
    chk_vld = 1'b0;
  endtask

  // One instruction: check result/skip in the drive cycle, Carry in the following cycle.
  task automatic run(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b,
                     input logic ex, input logic chk_comb, input logic [15:0] er,
                     input logic es, input logic ec);
    @(posedge pclk);
    #1;
    inst = i;
    op1  = a;
    op2  = b;
    exec = ex;
    if (chk_comb) begin
      exp_q.push_back('{is_carry: 1'b0, r: er, s: es, c: 1'b0});
      chk_vld = 1'b1;
    end
    @(posedge pclk);
    #1;
    exec = 1'b0;
    exp_q.push_back('{is_carry: 1'b1, r: 16'h0, s: 1'b0, c: ec});
    chk_vld = 1'b1;
    @(posedge pclk);
    #1;
    chk_vld = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    chk_vld = 1'b0;
    prst    = 1'b0;
    inst    = 16'h0;
    op1     = 16'h0;
    op2     = 16'h0;
    exec    = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    prst = 1'b1;

    chk_carry(1'b0);

    //   inst                       op1      op2      ex  cmp result   skip  carry
    run(mk(3'd6, 2'd0, 2'd0, 1'b0, 3'd4), 16'h0001, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1);
    run(mk(3'd5, 2'd0, 2'd1, 1'b0, 3'd3), 16'h0005, 16'h0003, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run(mk(3'd5, 2'd0, 2'd1, 1'b0, 3'd0), 16'h0003, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1);
    run(mk(3'd2, 2'd1, 2'd2, 1'b0, 3'd3), 16'h8001, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1);
    run(mk(3'd2, 2'd2, 2'd1, 1'b0, 3'd2), 16'h8001, 16'h0000, 1'b1, 1'b1, 16'h4000, 1'b0, 1'b1);
    run(mk(3'd2, 2'd3, 2'd1, 1'b0, 3'd6), 16'h1234, 16'h0000, 1'b1, 1'b1, 16'h3412, 1'b1, 1'b0);
    run(mk(3'd3, 2'd0, 2'd0, 1'b1, 3'd4), 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    run(mk(3'd1, 2'd0, 2'd1, 1'b0, 3'd7), 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1);
    run(mk(3'd0, 2'd0, 2'd1, 1'b0, 3'd5), 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'hFF00, 1'b1, 1'b0);
    run(mk(3'd7, 2'd0, 2'd2, 1'b0, 3'd7), 16'hF0F0, 16'h0FF0, 1'b1, 1'b1, 16'h00F0, 1'b1, 1'b1);
    run(mk(3'd4, 2'd0, 2'd0, 1'b0, 3'd1), 16'h0001, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    // exec low: the ADD would set Carry, so it must stay 0.
    run(mk(3'd6, 2'd0, 2'd1, 1'b0, 3'd2), 16'h0001, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    run(mk(3'd3, 2'd1, 2'd3, 1'b0, 3'd6), 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);
    run(mk(3'd1, 2'd0, 2'd1, 1'b0, 3'd3), 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle, well away from any rising edge.
    @(negedge pclk);
    #1;
    prst = 1'b0;
    #1;
    n_cmp++;
    if (carry !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: carry got %b required 0 before any clock edge", carry);
    end
    @(negedge pclk);
    prst = 1'b1;

    // Non-compute word with exec: Carry must not move.
    run(mk(3'd6, 2'd0, 2'd1, 1'b0, 3'd0) & 16'h7FFF, 16'h0001, 16'hFFFF, 1'b1, 1'b0,
        16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge pclk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
